// File: rtl/reg_mask_encoder.sv
// Serialises a 16-bit register mask into 4-bit register-select codes over valid/ready.
// Bit 8 has no code; it is dropped at load and flagged on err_r8.
module reg_mask_encoder #(
  parameter bit DESCENDING = 1'b0
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [15:0] mask,
  input  logic        ready,
  output logic        valid,
  output logic [3:0]  code,
  output logic        busy,
  output logic        done,
  output logic        err_r8,
  output logic [4:0]  count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] pending_q;
  logic [15:0] pending_d;
  logic [15:0] load_mask;
  logic        err_q;
  logic [4:0]  count_q;
  logic [3:0]  sel_idx;

  // Loop order makes the last match win: lowest bit when ascending, highest when descending.
  always_comb begin
    sel_idx = 4'd0;
    if (DESCENDING) begin
      for (int i = 0; i < 16; i++) begin
        if (pending_q[i]) sel_idx = 4'(i);
      end
    end else begin
      for (int i = 15; i >= 0; i--) begin
        if (pending_q[i]) sel_idx = 4'(i);
      end
    end
  end

  assign pending_d = pending_q & ~(16'd1 << sel_idx);
  assign load_mask = mask & 16'hFEFF;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      pending_q <= 16'd0;
      err_q     <= 1'b0;
      count_q   <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pending_q <= load_mask;
            err_q     <= mask[8];
            count_q   <= 5'd0;
            state_q   <= (load_mask == 16'd0) ? DONE : EMIT;
          end
        end
        EMIT: begin
          if (ready) begin
            pending_q <= pending_d;
            count_q   <= count_q + 5'd1;
            if (pending_d == 16'd0) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bit 8 is never pending, so indices above 8 shift down by one to close the gap.
  assign code   = (sel_idx > 4'd8) ? (sel_idx - 4'd1) : sel_idx;
  assign valid  = (state_q == EMIT);
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign err_r8 = err_q;
  assign count  = count_q;

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Directed bench: asc and desc instances share stimulus; each task checks its scenario inline.
module tb_reg_mask_encoder;

  logic        clock;
  logic        clear_n;
  logic        start;
  logic [15:0] mask;
  logic        ready;

  logic        valid0, busy0, done0, err0;
  logic [3:0]  code0;
  logic [4:0]  count0;
  logic        valid1, busy1, done1, err1;
  logic [3:0]  code1;
  logic [4:0]  count1;

  int pass_cnt = 0;
  int total_cnt = 0;

  reg_mask_encoder #(.DESCENDING(1'b0)) u_asc (
    .clock(clock), .clear_n(clear_n), .start(start), .mask(mask), .ready(ready),
    .valid(valid0), .code(code0), .busy(busy0), .done(done0), .err_r8(err0), .count(count0)
  );

  reg_mask_encoder #(.DESCENDING(1'b1)) u_desc (
    .clock(clock), .clear_n(clear_n), .start(start), .mask(mask), .ready(ready),
    .valid(valid1), .code(code1), .busy(busy1), .done(done1), .err_r8(err1), .count(count1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [15:0] m);
    start = 1'b1;
    mask  = m;
    step();
    start = 1'b0;
    mask  = 16'hA5A5;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if ({valid0, code0, busy0, done0, err0, count0} !== 13'd0 ||
        {valid1, code1, busy1, done1, err1, count1} !== 13'd0)
      $display("FAIL reset_outputs asc=%b desc=%b want all zero",
               {valid0, code0, busy0, done0, err0, count0},
               {valid1, code1, busy1, done1, err1, count1});
    else pass_cnt++;
    step();
    clear_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    ready = 1'b1;
    launch(16'h0005);
    total_cnt++;
    if ({valid0, code0, busy0} !== {1'b1, 4'd0, 1'b1} || code1 !== 4'd2)
      $display("FAIL basic_first asc v/c/b=%b/%0d/%b desc code=%0d want 1/0/1 desc 2",
               valid0, code0, busy0, code1);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({valid0, code0} !== {1'b1, 4'd2} || code1 !== 4'd0)
      $display("FAIL basic_second asc v/c=%b/%0d desc code=%0d want 1/2 desc 0",
               valid0, code0, code1);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({done0, valid0, count0, err0} !== {1'b1, 1'b0, 5'd2, 1'b0})
      $display("FAIL basic_done d/v/cnt/err=%b/%b/%0d/%b want 1/0/2/0",
               done0, valid0, count0, err0);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({done0, busy0, count0} !== {1'b0, 1'b0, 5'd2})
      $display("FAIL basic_idle d/b/cnt=%b/%b/%0d want 0/0/2", done0, busy0, count0);
    else pass_cnt++;
  endtask

  task automatic test_high_regs();
    ready = 1'b1;
    launch(16'h8200);
    total_cnt++;
    if ({valid0, code0} !== {1'b1, 4'd8} || code1 !== 4'd14)
      $display("FAIL r9_first asc code=%0d desc code=%0d want 8 / 14", code0, code1);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({valid0, code0} !== {1'b1, 4'd14} || code1 !== 4'd8)
      $display("FAIL r15_second asc code=%0d desc code=%0d want 14 / 8", code0, code1);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({done0, valid0, count0} !== {1'b1, 1'b0, 5'd2})
      $display("FAIL high_done d/v/cnt=%b/%b/%0d want 1/0/2", done0, valid0, count0);
    else pass_cnt++;
    step();
  endtask

  task automatic test_r8_only();
    ready = 1'b1;
    launch(16'h0100);
    total_cnt++;
    if ({valid0, done0, err0, count0} !== {1'b0, 1'b1, 1'b1, 5'd0} || err1 !== 1'b1)
      $display("FAIL r8_load v/d/err/cnt=%b/%b/%b/%0d desc err=%b want 0/1/1/0 err 1",
               valid0, done0, err0, count0, err1);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({done0, busy0, err0} !== {1'b0, 1'b0, 1'b1})
      $display("FAIL r8_hold d/b/err=%b/%b/%b want 0/0/1", done0, busy0, err0);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    ready = 1'b0;
    launch(16'h0111);
    for (int c = 0; c < 3; c++) begin
      total_cnt++;
      if ({valid0, code0, count0} !== {1'b1, 4'd0, 5'd0} || code1 !== 4'd4)
        $display("FAIL stall_hold cyc%0d asc v/c/cnt=%b/%0d/%0d desc code=%0d want 1/0/0 desc 4",
                 c, valid0, code0, count0, code1);
      else pass_cnt++;
      if (c < 2) step();
    end
    ready = 1'b1;
    step();
    total_cnt++;
    if ({valid0, code0, count0} !== {1'b1, 4'd4, 5'd1} || code1 !== 4'd0)
      $display("FAIL stall_next asc v/c/cnt=%b/%0d/%0d desc code=%0d want 1/4/1 desc 0",
               valid0, code0, count0, code1);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({done0, count0, err0} !== {1'b1, 5'd2, 1'b1})
      $display("FAIL stall_done d/cnt/err=%b/%0d/%b want 1/2/1", done0, count0, err0);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    ready = 1'b1;
    launch(16'hFFFF);
    for (int i = 0; i < 15; i++) begin
      total_cnt++;
      if ({valid1, code1} !== {1'b1, 4'(14 - i)} || {valid0, code0} !== {1'b1, 4'(i)})
        $display("FAIL b2b_code idx%0d desc v/c=%b/%0d asc v/c=%b/%0d want 1/%0d asc 1/%0d",
                 i, valid1, code1, valid0, code0, 14 - i, i);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({done1, valid1, count1, err1} !== {1'b1, 1'b0, 5'd15, 1'b1})
      $display("FAIL b2b_done d/v/cnt/err=%b/%b/%0d/%b want 1/0/15/1",
               done1, valid1, count1, err1);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid();
    ready = 1'b1;
    launch(16'hFFFF);
    step();
    step();
    total_cnt++;
    if ({valid0, code0, count0} !== {1'b1, 4'd2, 5'd2})
      $display("FAIL mid_third v/c/cnt=%b/%0d/%0d want 1/2/2", valid0, code0, count0);
    else pass_cnt++;
    clear_n = 1'b0;
    #1;
    total_cnt++;
    if ({valid0, code0, busy0, done0, err0, count0} !== 13'd0 ||
        {valid1, code1, busy1, done1, err1, count1} !== 13'd0)
      $display("FAIL mid_reset asc=%b desc=%b want all zero",
               {valid0, code0, busy0, done0, err0, count0},
               {valid1, code1, busy1, done1, err1, count1});
    else pass_cnt++;
    step();
    clear_n = 1'b1;
    step();
    total_cnt++;
    if ({done0, busy0} !== 2'b00)
      $display("FAIL mid_no_done d/b=%b/%b want 0/0", done0, busy0);
    else pass_cnt++;
    launch(16'h0002);
    total_cnt++;
    if ({valid0, code0, count0} !== {1'b1, 4'd1, 5'd0})
      $display("FAIL mid_restart v/c/cnt=%b/%0d/%0d want 1/1/0", valid0, code0, count0);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({done0, count0, err0} !== {1'b1, 5'd1, 1'b0})
      $display("FAIL mid_restart_done d/cnt/err=%b/%0d/%b want 1/1/0", done0, count0, err0);
    else pass_cnt++;
    step();
  endtask

  initial begin
    clear_n = 1'b0;
    start   = 1'b0;
    mask    = 16'd0;
    ready   = 1'b0;
    test_reset();
    test_basic();
    test_high_regs();
    test_r8_only();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
